// File: rtl/spi_tft_pkg.sv
// rtl/spi_tft_pkg.sv - shared types and constants for the SPI TFT receive path
// Contents: spi_rx_state_e (receiver FSM), SPI_BYTE_W, spi_rx_word_t (FIFO word).
package spi_tft_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } spi_rx_state_e;

  typedef struct packed {
    logic                  dc;
    logic [SPI_BYTE_W-1:0] data;
  } spi_rx_word_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - show-ahead synchronous FIFO of received SPI words
// Ports: clk, rst_n (async, active low); wr_en/wr_data push side;
//        rd_en/rd_data pop side (rd_data shows the head word, 0 when empty);
//        full, empty status. A write on a full FIFO succeeds only with a
//        simultaneous read.
module spi_rx_fifo
  import spi_tft_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  spi_rx_word_t wr_data,
  input  logic         rd_en,
  output spi_rx_word_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  spi_rx_word_t     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_tft_receiver.sv
// rtl/spi_tft_receiver.sv - oversampling SPI slave that reassembles tagged bytes
// Ports: clk, rst_n (async, active low); cs_in/sclk_in/mosi_in/dc_in raw SPI pins;
//        rx_data/rx_dc/rx_valid/rx_ready output stream; frame_err pulse on a
//        truncated byte; overflow sticky drop flag, cleared by ovf_clr.
// Build option: SPI_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a
//        single holding register.
module spi_tft_receiver
  import spi_tft_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_in,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  dc_in,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_dc,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, dc_sync;
  logic cs_s, sclk_s, mosi_s, dc_s;
  logic cs_d, sclk_d;
  logic sclk_rise, cs_fall, cs_rise;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s && !sclk_d;
  assign cs_fall   = !cs_s && cs_d;
  assign cs_rise   = cs_s && !cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc_in};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  // Pipeline: sclk rise -> cap_pend -> shift/capture -> push_q -> buffer.
  // The register between capture and buffer keeps the rx_valid latency
  // identical for the FIFO and holding-register builds.
  spi_rx_state_e           state, state_n;
  logic [2:0]              bit_cnt, bit_cnt_n;
  logic [SPI_BYTE_W-2:0]   shreg, shreg_n;
  logic                    cap_pend, cap_n;
  logic                    push_q, push_n;
  spi_rx_word_t            push_word, word_n;
  logic                    err_q, err_n;

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    cap_n     = 1'b0;
    push_n    = 1'b0;
    word_n    = push_word;
    err_n     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (cs_fall) begin
          state_n   = RX_SHIFT;
          bit_cnt_n = '0;
          shreg_n   = '0;
        end
      end
      RX_SHIFT: begin
        cap_n = sclk_rise && !cs_s;
        if (cap_pend) begin
          shreg_n   = {shreg[SPI_BYTE_W-3:0], mosi_s};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            push_n = 1'b1;
            word_n = '{dc: dc_s, data: {shreg, mosi_s}};
          end
        end
        if (cs_rise) begin
          state_n = RX_IDLE;
          // A capture completing the byte in this same cycle is a clean end.
          err_n   = cap_pend ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      cap_pend  <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
      err_q     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      cap_pend  <= cap_n;
      push_q    <= push_n;
      push_word <= word_n;
      err_q     <= err_n;
      frame_err <= err_q;
    end
  end

  logic drop;

`ifdef SPI_RX_FIFO_EN
  logic         fifo_full, fifo_empty, pop, push_ok;
  spi_rx_word_t head;

  assign pop     = rx_valid && rx_ready;
  assign push_ok = push_q && (!fifo_full || pop);
  assign drop    = push_q && !push_ok;

  spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_ok),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = head.data;
  assign rx_dc    = head.dc;
`else
  spi_rx_word_t hold;
  logic         hold_v;

  assign drop = push_q && hold_v && !rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (push_q && !drop) begin
      hold   <= push_word;
      hold_v <= 1'b1;
    end else if (hold_v && rx_ready) begin
      hold_v <= 1'b0;
    end
  end

  assign rx_valid = hold_v;
  assign rx_data  = hold.data;
  assign rx_dc    = hold.dc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_spi_tft_receiver.sv
// tb/tb_spi_tft_receiver.sv - directed self-checking bench for spi_tft_receiver
module tb_spi_tft_receiver;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_in = 1'b1;
  logic       sclk_in = 1'b0;
  logic       mosi_in = 1'b0;
  logic       dc_in = 1'b0;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  spi_tft_receiver #(.FIFO_DEPTH(4), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_in     (cs_in),
    .sclk_in   (sclk_in),
    .mosi_in   (mosi_in),
    .dc_in     (dc_in),
    .rx_data   (rx_data),
    .rx_dc     (rx_dc),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] beats[$];
  int   vrise_cyc = -1;
  int   ferr_cnt = 0;
  int   ferr_cyc = -1;
  logic valid_prev = 1'b0;
  int   last_samp = 0;
  int   cs_samp = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) beats.push_back({rx_dc, rx_data});
    if (rx_valid && !valid_prev && vrise_cyc < 0) vrise_cyc = cyc;
    valid_prev = rx_valid;
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] beat(input int i);
    return (beats.size() > i) ? beats[i] : 9'h1FF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b, input logic d);
    mosi_in = b;
    dc_in   = d;
    tick(HALF);
    sclk_in   = 1'b1;
    last_samp = cyc + 1;
    tick(HALF);
    sclk_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    for (int i = 7; i >= 0; i--) send_bit(b[i], d);
  endtask

  task automatic cs_low();
    cs_in = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    cs_in   = 1'b1;
    cs_samp = cyc + 1;
    tick(8);
  endtask

  initial begin
    logic [7:0] stall_bytes[6];
    stall_bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};

    tick(3);
    check("reset_outputs", {rx_valid, rx_data, rx_dc, frame_err, overflow}, 12'h000);
    rst_n = 1'b1;
    tick(4);

    // Single command byte, latency
    beats.delete();
    vrise_cyc = -1;
    ferr_cnt = 0;
    cs_low();
    send_byte(8'h01, 1'b0);
    cs_high();
    tick(10);
    check("single_count", beats.size(), 1);
    check("single_beat", beat(0), 9'h001);
    check("single_latency", vrise_cyc, last_samp + SYNC + 2);
    check("single_no_ferr", ferr_cnt, 0);

    // Three bytes in one window
    beats.delete();
    cs_low();
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h7F, 1'b1);
    cs_high();
    tick(10);
    check("multi_count", beats.size(), 3);
    check("multi_b0", beat(0), 9'h001);
    check("multi_b1", beat(1), 9'h011);
    check("multi_b2", beat(2), 9'h17F);

    // Truncated byte then a good one
    beats.delete();
    ferr_cnt = 0;
    cs_low();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    cs_high();
    tick(4);
    check("trunc_ferr_cnt", ferr_cnt, 1);
    check("trunc_ferr_time", ferr_cyc, cs_samp + SYNC + 1);
    check("trunc_no_beat", beats.size(), 0);
    cs_low();
    send_byte(8'hA5, 1'b1);
    cs_high();
    tick(10);
    check("after_trunc_count", beats.size(), 1);
    check("after_trunc_beat", beat(0), 9'h1A5);
    check("after_trunc_ferr", ferr_cnt, 1);

    // Stall with six bytes
    beats.delete();
    rx_ready = 1'b0;
    cs_low();
    for (int i = 0; i < 6; i++) send_byte(stall_bytes[i], 1'b1);
    cs_high();
    tick(4);
    check("stall_valid", rx_valid, 1'b1);
    check("stall_head", {rx_dc, rx_data}, 9'h110);
    check("stall_overflow", overflow, 1'b1);
    rx_ready = 1'b1;
    tick(10);
`ifdef SPI_RX_FIFO_EN
    check("stall_pop_count", beats.size(), 4);
    for (int i = 0; i < 4; i++) check("stall_pop", beat(i), {1'b1, stall_bytes[i]});
`else
    check("stall_pop_count", beats.size(), 1);
    check("stall_pop", beat(0), 9'h110);
`endif
    check("stall_drained", rx_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Reset mid-byte
    ferr_cnt = 0;
    cs_low();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst_n   = 1'b0;
    cs_in   = 1'b1;
    #1;
    check("in_reset_outputs", {rx_valid, rx_data, rx_dc, frame_err, overflow}, 12'h000);
    tick(3);
    check("in_reset_hold", {rx_valid, rx_data, rx_dc, frame_err, overflow}, 12'h000);
    rst_n = 1'b1;
    tick(4);
    beats.delete();
    cs_low();
    send_byte(8'h3C, 1'b0);
    cs_high();
    tick(10);
    check("post_reset_count", beats.size(), 1);
    check("post_reset_beat", beat(0), 9'h03C);
    check("post_reset_no_ferr", ferr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
